// File: rtl/mem_lsu_buffered_if.sv
// Request/response and memory-bus bundle for the buffered MEM-stage load/store unit.
// The slave modport is the LSU; the master modport is the pipeline plus memory side.
interface mem_lsu_buffered_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_type;
  logic [2:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_addr_error;
  logic              mem_en;
  logic [NB-1:0]     mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_type, req_size, req_signed, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_addr_error,
    output mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_type, req_size, req_signed, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_addr_error,
    input  mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_lsu_buffered.sv
// MEM-stage load/store unit: stores retire into a FIFO store buffer that drains in the
// background; non-conflicting loads bypass it, conflicting loads stall until the drain.
module mem_lsu_buffered #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_lsu_buffered_if.slave bus
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned OB = $clog2(NB);
  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LD_REQ  = 2'd1;
  localparam logic [1:0] LD_WAIT = 2'd2;

  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_STORE = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     mask;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  logic [1:0]        state, state_d;
  logic [ADDR_W-1:0] ld_addr, ld_addr_d;
  logic [2:0]        ld_size, ld_size_d;
  logic              ld_signed, ld_signed_d;

  logic              mem_en, mem_en_d;
  logic [NB-1:0]     mem_wen, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata, mem_wdata_d;
  logic              resp_valid, resp_valid_d;
  logic [DATA_W-1:0] resp_data, resp_data_d;
  logic              resp_err, resp_err_d;

  sb_entry_t         sb_mem [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PW-1:0]     rd_ptr, wr_ptr, head_ptr;
  logic [CW-1:0]     count, sb_left;
  sb_entry_t         head;

  logic [OB-1:0]     off;
  logic              is_load, is_store, size_err, conflict, sb_full, ready;
  logic              accept, acc_ld, acc_st, acc_err, push, pop;
  logic              beat_done, ld_beat, bus_free;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] shifted, ext_mask, ld_result;
  logic              sign_bit;

  // Request decode and acceptance
  assign off      = bus.req_addr[OB-1:0];
  assign is_load  = (bus.req_type == T_LOAD);
  assign is_store = (bus.req_type == T_STORE);
  assign sb_full  = (count == CW'(SB_DEPTH));

  always_comb begin
    size_err = 1'b0;
    case (bus.req_size)
      3'd0:    size_err = 1'b0;
      3'd1:    size_err = bus.req_addr[0];
      3'd2:    size_err = (bus.req_addr[1:0] != 2'b00);
      3'd3:    size_err = (DATA_W != 64) || (bus.req_addr[2:0] != 3'b000);
      default: size_err = 1'b1;
    endcase
  end

  // A load must not overtake a buffered store to the same bus word
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_vld[i] && (sb_mem[i].addr[ADDR_W-1:OB] == bus.req_addr[ADDR_W-1:OB]))
        conflict = 1'b1;
    end
  end

  assign ready   = rst && (state == IDLE) && !(is_store && sb_full) && !(is_load && conflict);
  assign accept  = bus.req_valid && ready;
  assign acc_err = accept && (is_load || is_store) && size_err;
  assign acc_st  = accept && is_store && !size_err;
  assign acc_ld  = accept && is_load && !size_err;

  always_comb begin
    lane_mask = '0;
    wdata_rep = '0;
    case (bus.req_size)
      3'd0: begin
        lane_mask = NB'(1) << off;
        wdata_rep = {NB{bus.req_wdata[7:0]}};
      end
      3'd1: begin
        lane_mask = NB'(3) << off;
        wdata_rep = {(NB/2){bus.req_wdata[15:0]}};
      end
      3'd2: begin
        lane_mask = NB'(15) << off;
        wdata_rep = {(NB/4){bus.req_wdata[31:0]}};
      end
      default: begin
        lane_mask = '1;
        wdata_rep = bus.req_wdata;
      end
    endcase
  end

  // Bus beat tracking; a store beat always has a non-zero lane mask
  assign beat_done = mem_en && bus.mem_gnt;
  assign ld_beat   = mem_en && (mem_wen == '0);
  assign bus_free  = !mem_en || beat_done;
  assign push      = acc_st;
  assign pop       = beat_done && !ld_beat;
  assign sb_left   = count - CW'(pop);
  assign head_ptr  = rd_ptr + PW'(pop);
  assign head      = sb_mem[head_ptr];

  // Load data extraction and extension
  always_comb begin
    shifted  = bus.mem_rdata >> {ld_addr[OB-1:0], 3'b000};
    ext_mask = '1;
    sign_bit = 1'b0;
    case (ld_size)
      3'd0:    begin ext_mask = DATA_W'(8'hFF);         sign_bit = shifted[7];  end
      3'd1:    begin ext_mask = DATA_W'(16'hFFFF);      sign_bit = shifted[15]; end
      3'd2:    begin ext_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin ext_mask = '1;                     sign_bit = 1'b0;        end
    endcase
    ld_result = (shifted & ext_mask) | ({DATA_W{ld_signed & sign_bit}} & ~ext_mask);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    ld_addr_d    = ld_addr;
    ld_size_d    = ld_size;
    ld_signed_d  = ld_signed;
    mem_en_d     = mem_en && !bus.mem_gnt;
    mem_wen_d    = mem_wen;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (acc_ld) begin
          state_d     = LD_REQ;
          ld_addr_d   = bus.req_addr;
          ld_size_d   = bus.req_size;
          ld_signed_d = bus.req_signed;
          if (bus_free) begin
            mem_en_d    = 1'b1;
            mem_wen_d   = '0;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = '0;
          end
        end else if (bus_free && (sb_left != '0)) begin
          mem_en_d    = 1'b1;
          mem_wen_d   = head.mask;
          mem_addr_d  = head.addr;
          mem_wdata_d = head.data;
        end
        if (acc_st || acc_err) begin
          resp_valid_d = 1'b1;
          resp_data_d  = DATA_W'(bus.req_addr);
          resp_err_d   = acc_err;
        end
      end
      LD_REQ: begin
        if (ld_beat) begin
          if (bus.mem_gnt) state_d = LD_WAIT;
        end else if (bus_free) begin
          mem_en_d    = 1'b1;
          mem_wen_d   = '0;
          mem_addr_d  = ld_addr;
          mem_wdata_d = '0;
        end
      end
      LD_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = ld_result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ld_addr    <= '0;
      ld_size    <= '0;
      ld_signed  <= 1'b0;
      mem_en     <= 1'b0;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      ld_addr    <= ld_addr_d;
      ld_size    <= ld_size_d;
      ld_signed  <= ld_signed_d;
      mem_en     <= mem_en_d;
      mem_wen    <= mem_wen_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
    end
  end

  // Store-buffer pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      sb_vld <= '0;
    end else begin
      count  <= count + CW'(push) - CW'(pop);
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      if (pop)  sb_vld[rd_ptr] <= 1'b0;
      if (push) sb_vld[wr_ptr] <= 1'b1;
    end
  end

  // Entry payloads are qualified by sb_vld, so they need no reset
  always_ff @(posedge clk) begin
    if (push) sb_mem[wr_ptr] <= '{addr: bus.req_addr, mask: lane_mask, data: wdata_rep};
  end

  assign bus.req_ready       = ready;
  assign bus.resp_valid      = resp_valid;
  assign bus.resp_data       = resp_data;
  assign bus.resp_addr_error = resp_err;
  assign bus.mem_en          = mem_en;
  assign bus.mem_wen         = mem_wen;
  assign bus.mem_addr        = mem_addr;
  assign bus.mem_wdata       = mem_wdata;

endmodule

// File: tb/tb_mem_lsu_buffered.sv
// Directed bench for mem_lsu_buffered (DATA_W=32, SB_DEPTH=4): inputs change and outputs
// are sampled around the falling edge; all expected values are hand-computed constants.
module tb_mem_lsu_buffered;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned SB_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_lsu_buffered_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_lsu_buffered #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] t, input logic [2:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
    bus.req_valid  = 1'b1;
    bus.req_type   = t;
    bus.req_size   = s;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
  endtask

  task automatic clr_req();
    bus.req_valid = 1'b0;
    bus.req_type  = 2'd0;
  endtask

  // One accepted request; checks the response visible one cycle later
  task automatic send(input string tag, input logic [1:0] t, input logic [2:0] s,
                      input logic sg, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_resp, input logic exp_err);
    set_req(t, s, sg, a, d);
    #1 check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    clr_req();
    check({tag, "_rvalid"}, 32'(bus.resp_valid), 32'(exp_resp));
    if (exp_resp) begin
      check({tag, "_err"}, 32'(bus.resp_addr_error), 32'(exp_err));
      check({tag, "_rdata"}, bus.resp_data, a);
    end
  endtask

  // Load issued on a free bus: grant after gdel cycles, rvalid one cycle after grant
  task automatic do_load(input string tag, input logic [2:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] rd, input int gdel,
                         input logic [31:0] exp);
    bus.mem_gnt = 1'b0;
    send(tag, 2'd1, s, sg, a, 32'd0, 1'b0, 1'b0);
    check({tag, "_en"}, 32'(bus.mem_en), 32'd1);
    check({tag, "_wen"}, 32'(bus.mem_wen), 32'd0);
    check({tag, "_addr"}, bus.mem_addr, a);
    for (int i = 0; i < gdel; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, 32'(bus.mem_en), 32'd1);
      check({tag, "_early"}, 32'(bus.resp_valid), 32'd0);
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check({tag, "_en_off"}, 32'(bus.mem_en), 32'd0);
    check({tag, "_wait"}, 32'(bus.resp_valid), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd1);
    check({tag, "_err"}, 32'(bus.resp_addr_error), 32'd0);
    check({tag, "_data"}, bus.resp_data, exp);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_type   = 2'd0;
    bus.req_size   = 3'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_en", 32'(bus.mem_en), 32'd0);
    check("rst_wen", 32'(bus.mem_wen), 32'd0);
    check("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Store word with immediate grant
    bus.mem_gnt = 1'b1;
    send("st_w", 2'd2, 3'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("st_w_en0", 32'(bus.mem_en), 32'd0);
    @(negedge clk);
    check("st_w_en", 32'(bus.mem_en), 32'd1);
    check("st_w_wen", 32'(bus.mem_wen), 32'hF);
    check("st_w_addr", bus.mem_addr, 32'h10);
    check("st_w_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("st_w_done", 32'(bus.mem_en), 32'd0);
    bus.mem_gnt = 1'b0;

    // Noop and errored requests
    send("noop", 2'd0, 3'd2, 1'b0, 32'h44, 32'd0, 1'b0, 1'b0);
    send("ld_h3", 2'd1, 3'd1, 1'b0, 32'h3, 32'd0, 1'b1, 1'b1);
    check("ld_h3_en", 32'(bus.mem_en), 32'd0);
    send("ld_d8", 2'd1, 3'd3, 1'b0, 32'h8, 32'd0, 1'b1, 1'b1);
    send("st_w5", 2'd2, 3'd2, 1'b0, 32'h5, 32'h1234, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("err_no_beat", 32'(bus.mem_en), 32'd0);

    // Load extraction and extension, rdata = 0x80FF7F01
    do_load("lb1s", 3'd0, 1'b1, 32'h1, 32'h80FF_7F01, 0, 32'h0000_007F);
    do_load("lb2s", 3'd0, 1'b1, 32'h2, 32'h80FF_7F01, 2, 32'hFFFF_FFFF);
    do_load("lh2u", 3'd1, 1'b0, 32'h2, 32'h80FF_7F01, 0, 32'h0000_80FF);
    do_load("lh2s", 3'd1, 1'b1, 32'h2, 32'h80FF_7F01, 1, 32'hFFFF_80FF);
    do_load("lh0s", 3'd1, 1'b1, 32'h0, 32'h80FF_7F01, 0, 32'h0000_7F01);
    do_load("lw0", 3'd2, 1'b1, 32'h0, 32'h80FF_7F01, 0, 32'h80FF_7F01);

    // Fill the store buffer with the grant held low
    send("f0", 2'd2, 3'd0, 1'b0, 32'h101, 32'hA5, 1'b1, 1'b0);
    send("f1", 2'd2, 3'd1, 1'b0, 32'h202, 32'h1234, 1'b1, 1'b0);
    send("f2", 2'd2, 3'd2, 1'b0, 32'h300, 32'hCAFE_F00D, 1'b1, 1'b0);
    send("f3", 2'd2, 3'd0, 1'b0, 32'h403, 32'h77, 1'b1, 1'b0);
    check("f_addr0", bus.mem_addr, 32'h101);
    check("f_wen0", 32'(bus.mem_wen), 32'h2);
    check("f_wdata0", bus.mem_wdata, 32'hA5A5_A5A5);
    set_req(2'd2, 3'd0, 1'b0, 32'h500, 32'h3C);
    #1 check("f_full", 32'(bus.req_ready), 32'd0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    #1 check("f_ready", 32'(bus.req_ready), 32'd1);
    check("f_addr1", bus.mem_addr, 32'h202);
    check("f_wen1", 32'(bus.mem_wen), 32'hC);
    check("f_wdata1", bus.mem_wdata, 32'h1234_1234);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    clr_req();
    check("f_pp_rvalid", 32'(bus.resp_valid), 32'd1);
    check("f_pp_rdata", bus.resp_data, 32'h500);
    check("f_addr2", bus.mem_addr, 32'h300);
    check("f_wen2", 32'(bus.mem_wen), 32'hF);
    send("f6", 2'd2, 3'd2, 1'b0, 32'h600, 32'h600D_CAFE, 1'b1, 1'b0);
    set_req(2'd2, 3'd2, 1'b0, 32'h700, 32'h7);
    #1 check("f_full2", 32'(bus.req_ready), 32'd0);
    clr_req();
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    check("d_addr3", bus.mem_addr, 32'h403);
    check("d_wen3", 32'(bus.mem_wen), 32'h8);
    check("d_wdata3", bus.mem_wdata, 32'h7777_7777);
    @(negedge clk);
    check("d_addr4", bus.mem_addr, 32'h500);
    check("d_wen4", 32'(bus.mem_wen), 32'h1);
    check("d_wdata4", bus.mem_wdata, 32'h3C3C_3C3C);
    @(negedge clk);
    check("d_addr5", bus.mem_addr, 32'h600);
    check("d_wdata5", bus.mem_wdata, 32'h600D_CAFE);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("d_empty", 32'(bus.mem_en), 32'd0);

    // Load conflicting with a buffered store stalls until the store is granted
    send("cs", 2'd2, 3'd2, 1'b0, 32'h20, 32'h5555_AAAA, 1'b1, 1'b0);
    set_req(2'd1, 3'd1, 1'b0, 32'h22, 32'd0);
    #1 check("cf_stall0", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    #1 check("cf_stall1", 32'(bus.req_ready), 32'd0);
    check("cf_st_addr", bus.mem_addr, 32'h20);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    do_load("cf_ld", 3'd1, 1'b0, 32'h22, 32'h5555_AAAA, 0, 32'h0000_5555);

    // Non-conflicting load takes the bus after the current beat, ahead of queued stores
    send("bs0", 2'd2, 3'd2, 1'b0, 32'h80, 32'h1, 1'b1, 1'b0);
    send("bs1", 2'd2, 3'd2, 1'b0, 32'h84, 32'h2, 1'b1, 1'b0);
    send("bp", 2'd1, 3'd2, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0);
    check("bp_cur_addr", bus.mem_addr, 32'h80);
    check("bp_cur_wen", 32'(bus.mem_wen), 32'hF);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("bp_ld_en", 32'(bus.mem_en), 32'd1);
    check("bp_ld_wen", 32'(bus.mem_wen), 32'd0);
    check("bp_ld_addr", bus.mem_addr, 32'h40);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("bp_wait_en", 32'(bus.mem_en), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("bp_rvalid", 32'(bus.resp_valid), 32'd1);
    check("bp_rdata", bus.resp_data, 32'h1234_5678);
    @(negedge clk);
    check("bp_drain_en", 32'(bus.mem_en), 32'd1);
    check("bp_drain_addr", bus.mem_addr, 32'h84);
    check("bp_drain_wdata", bus.mem_wdata, 32'h2);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("bp_drain_done", 32'(bus.mem_en), 32'd0);

    // Reset while a load waits for read data, with a store still buffered
    send("rs0", 2'd2, 3'd2, 1'b0, 32'h90, 32'h90, 1'b1, 1'b0);
    send("rs1", 2'd2, 3'd2, 1'b0, 32'h94, 32'h94, 1'b1, 1'b0);
    send("rl", 2'd1, 3'd0, 1'b0, 32'h48, 32'd0, 1'b0, 1'b0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    check("rl_addr", bus.mem_addr, 32'h48);
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("rl_wait_addr", bus.mem_addr, 32'h48);
    #2 rst = 1'b0;
    #1;
    check("rw_addr", bus.mem_addr, 32'd0);
    check("rw_en", 32'(bus.mem_en), 32'd0);
    check("rw_ready", 32'(bus.req_ready), 32'd0);
    check("rw_rvalid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFF;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    check("rw_stale", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    check("rw_sb_empty", 32'(bus.mem_en), 32'd0);
    send("post", 2'd2, 3'd0, 1'b0, 32'h7, 32'h5A, 1'b1, 1'b0);
    @(negedge clk);
    check("post_en", 32'(bus.mem_en), 32'd1);
    check("post_addr", bus.mem_addr, 32'h7);
    check("post_wen", 32'(bus.mem_wen), 32'h8);
    check("post_wdata", bus.mem_wdata, 32'h5A5A_5A5A);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    check("post_done", 32'(bus.mem_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
